status_reporter: RTL
====================

STATUS_REPORTER -- requirements
Module: status_reporter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of count_down input.
REQ-002 SHALL have parameter SCORE_DIGITS, default 4, number of BCD score nibbles reported.
REQ-003 SHALL have one clock and asynchronous active-low reset: ports clk and reset_n; polarity and synchronicity fixed.
REQ-004 clk  input  1  system clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  game-running level from control.
REQ-007 over  input  1  game-over level from control.
REQ-008 score  input  4*SCORE_DIGITS  BCD score, digit 0 in bits [3:0].
REQ-009 count_down  input  CNT_W  remaining seconds, binary.
REQ-010 is_transmitting  input  1  uart busy flag.
REQ-011 transmit  output  1  one-cycle send strobe to uart.
REQ-012 tx_byte  output  8  byte presented with transmit.
REQ-013 busy  output  1  high while any message is in flight.

Function
REQ-014 SHALL report game events over uart as ASCII messages, each ending with 0x0D 0x0A.
REQ-015 SHALL use messages: START "START", OVER "OVER", SCORE "S:" plus SCORE_DIGITS digits (MS first), TIME "T:" plus two uppercase hex digits of count_down[7:0].
REQ-016 SHALL set a pending flag on: start rising edge (START), over rising edge (OVER), score != last sampled score (SCORE), count_down != last sampled value while start=1 (TIME).
REQ-017 SHALL keep one pending flag per type; a repeat event while pending SHALL not queue a second message.
REQ-018 SHALL snapshot score/count_down when a message is loaded; sent digits are the latest values at load time.
REQ-019 SHALL select among pending messages with priority OVER > START > SCORE > TIME, and clear the selected flag at load.
REQ-020 SHALL implement FSM IDLE -> LOAD -> STROBE -> WAIT_BUSY -> WAIT_DONE -> (STROBE for next byte | IDLE after 0x0A).
REQ-021 SHALL assert transmit for exactly one cycle in STROBE, only when is_transmitting=0, with tx_byte stable from that cycle until WAIT_DONE exits.
REQ-022 SHALL leave WAIT_BUSY on is_transmitting=1 and WAIT_DONE on is_transmitting=0.
REQ-023 SHALL encode BCD nibble n<=9 as 0x30+n, nibble >9 as "?" (0x3F).
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL never interleave bytes of two messages; events during a message only set flags.
REQ-026 SHALL clear pending TIME and SCORE flags (not OVER) when start falls to 0 before they are loaded.

Reset
REQ-027 On reset_n=0 SHALL immediately force transmit=0, tx_byte=0x00, busy=0, FSM=IDLE, all pending flags 0, sampled score=0, sampled count_down=0, prior start/over=0.
REQ-028 Reset mid-message SHALL abandon the message; no further bytes after reset release without a new event.

Configuration
REQ-029 Macro REPORT_TIME_EN: defined -> TIME messages generated per REQ-016; undefined -> TIME flag, snapshot and hex encoder absent, count_down ignored.

Structure
REQ-030 Message-type enum, ASCII constants (CR, LF, ':'), and FSM state enum SHALL live in shared package enum_type.
REQ-031 One sub-module msg_rom SHALL map (message type, byte index, snapshot) to byte and last-byte flag combinationally.

Verification
REQ-032 score 0x0000 -> 0x0012 with start=1 -> bytes 53 3A 30 30 31 32 0D 0A, each with one transmit pulse.
REQ-033 start and score change in same cycle -> "START\r\n" fully, then "S:dddd\r\n"; no interleave.
REQ-034 over rises while SCORE message mid-flight -> SCORE completes, then 4F 56 45 52 0D 0A.
REQ-035 reset_n low at byte 3 of a message -> transmit=0, tx_byte=00, busy=0 same cycle; silent after release.
REQ-036 REPORT_TIME_EN defined, count_down 0x1E -> 0x1D -> "T:1D\r\n"; undefined -> no bytes.
REQ-037 score nibble 0xA -> digit byte 0x3F.

Source files
------------

// File: rtl/status_reporter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enum_type (package)
//  Description : Shared types for the status reporter: message-type enum,
//                FSM state enum, ASCII constants and character encoders.
//                Optional feature macro used by the importing files:
//                REPORT_TIME_EN (enables TIME messages).
//  Revision    : 1.0 - initial release
// ============================================================================
package enum_type;

    // Message kinds the reporter can emit
    typedef enum logic [1:0] {
        MSG_START = 2'd0,
        MSG_OVER  = 2'd1,
        MSG_SCORE = 2'd2,
        MSG_TIME  = 2'd3
    } msg_t;

    // Transmit sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_STROBE    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;
    localparam logic [7:0] c_ascii_colon = 8'h3A;
    localparam logic [7:0] c_ascii_qmark = 8'h3F;

    // Byte index width; covers the longest message for any sane digit count
    localparam int c_idx_w = 5;

    // BCD digit to ASCII; anything that is not a decimal digit becomes '?'
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : c_ascii_qmark;
    endfunction

    // Nibble to uppercase hex ASCII ('A' = 0x37 + 10)
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage
`default_nettype wire

// File: rtl/status_reporter_msg_rom.sv
`default_nettype none
// ============================================================================
//  Module      : msg_rom
//  Description : Combinational message table. Maps (message type, byte
//                index, score/time snapshot) to the byte to send and a flag
//                marking the final byte (the LF).
//                Macro REPORT_TIME_EN: adds the "T:hh" message.
//  Ports       : msg_type   - message being sent
//                idx        - byte position within the message
//                score_snap - BCD score snapshot, digit 0 in [3:0]
//                time_snap  - count_down[7:0] snapshot
//                byte_out   - byte at idx
//                last       - byte_out is the terminating LF
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_rom
    import enum_type::*;
#(
    parameter int SCORE_DIGITS = 4
) (
    input  msg_t                      msg_type,
    input  logic [c_idx_w-1:0]        idx,
    input  logic [4*SCORE_DIGITS-1:0] score_snap,
    input  logic [7:0]                time_snap,
    output logic [7:0]                byte_out,
    output logic                      last
);

    int w_pos;
    int w_dig;

`ifndef REPORT_TIME_EN
    logic w_unused_time;
    assign w_unused_time = ^time_snap;
`endif

    always_comb begin
        byte_out = 8'h00;
        last     = 1'b0;
        w_pos    = int'(idx);
        // Digits go out most-significant first: position 2 is the top digit
        w_dig    = SCORE_DIGITS + 1 - w_pos;
        case (msg_type)
            MSG_START: begin
                case (idx)
                    5'd0: byte_out = "S";
                    5'd1: byte_out = "T";
                    5'd2: byte_out = "A";
                    5'd3: byte_out = "R";
                    5'd4: byte_out = "T";
                    5'd5: byte_out = c_ascii_cr;
                    5'd6: begin byte_out = c_ascii_lf; last = 1'b1; end
                    default: ;
                endcase
            end
            MSG_OVER: begin
                case (idx)
                    5'd0: byte_out = "O";
                    5'd1: byte_out = "V";
                    5'd2: byte_out = "E";
                    5'd3: byte_out = "R";
                    5'd4: byte_out = c_ascii_cr;
                    5'd5: begin byte_out = c_ascii_lf; last = 1'b1; end
                    default: ;
                endcase
            end
            MSG_SCORE: begin
                if (w_pos == 0) begin
                    byte_out = "S";
                end else if (w_pos == 1) begin
                    byte_out = c_ascii_colon;
                end else if (w_pos < SCORE_DIGITS + 2) begin
                    byte_out = bcd_to_ascii(score_snap[4*w_dig +: 4]);
                end else if (w_pos == SCORE_DIGITS + 2) begin
                    byte_out = c_ascii_cr;
                end else if (w_pos == SCORE_DIGITS + 3) begin
                    byte_out = c_ascii_lf;
                    last     = 1'b1;
                end
            end
`ifdef REPORT_TIME_EN
            MSG_TIME: begin
                case (idx)
                    5'd0: byte_out = "T";
                    5'd1: byte_out = c_ascii_colon;
                    5'd2: byte_out = hex_to_ascii(time_snap[7:4]);
                    5'd3: byte_out = hex_to_ascii(time_snap[3:0]);
                    5'd4: byte_out = c_ascii_cr;
                    5'd5: begin byte_out = c_ascii_lf; last = 1'b1; end
                    default: ;
                endcase
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/status_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : status_reporter
//  Description : Watches game control/score/timer levels and reports events
//                to a UART as CR/LF-terminated ASCII messages, one byte per
//                transmit strobe, one message at a time.
//                Macro REPORT_TIME_EN: enables "T:hh" messages on count_down
//                change while the game runs; otherwise count_down is ignored.
//  Ports       : clk, reset_n (async, active low)
//                start, over          - game running / game over levels
//                score                - BCD score, digit 0 in [3:0]
//                count_down           - remaining seconds, binary
//                is_transmitting      - UART busy flag
//                transmit, tx_byte    - one-cycle send strobe and its byte
//                busy                 - a message is in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module status_reporter
    import enum_type::*;
#(
    parameter int CNT_W        = 8,
    parameter int SCORE_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      over,
    input  logic [4*SCORE_DIGITS-1:0] score,
    input  logic [CNT_W-1:0]          count_down,
    input  logic                      is_transmitting,
    output logic                      transmit,
    output logic [7:0]                tx_byte,
    output logic                      busy
);

    localparam int c_score_w = 4 * SCORE_DIGITS;

    state_t               r_state;
    msg_t                 r_msg_type;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_last;
    logic [c_score_w-1:0] r_score_snap;
    logic [c_score_w-1:0] r_score_smp;
    logic                 r_start_d;
    logic                 r_over_d;
    logic                 r_pend_start;
    logic                 r_pend_over;
    logic                 r_pend_score;

    logic                 w_pend_time;
    logic [7:0]           w_time_live;
    logic [7:0]           w_rom_time;
    msg_t                 w_sel;
    msg_t                 w_rom_type;
    logic [c_score_w-1:0] w_rom_score;
    logic [c_idx_w-1:0]   w_rom_idx;
    logic [7:0]           w_rom_byte;
    logic                 w_rom_last;
    logic                 w_any_pend;
    logic                 w_load;
    logic                 w_start_fall;

    assign w_start_fall = r_start_d & ~start;
    assign w_any_pend   = r_pend_over | r_pend_start | r_pend_score | w_pend_time;
    assign w_load       = (r_state == ST_LOAD) && w_any_pend && !is_transmitting;

`ifdef REPORT_TIME_EN
    logic [CNT_W-1:0] r_cnt_smp;
    logic             r_pend_time;
    logic [7:0]       r_time_snap;

    if (CNT_W >= 8) begin : g_cnt_wide
        assign w_time_live = count_down[7:0];
    end else begin : g_cnt_narrow
        assign w_time_live = {{(8-CNT_W){1'b0}}, count_down};
    end

    assign w_pend_time = r_pend_time;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_smp   <= '0;
            r_pend_time <= 1'b0;
        end else begin
            r_cnt_smp <= count_down;
            if (start && (count_down != r_cnt_smp))
                r_pend_time <= 1'b1;
            if ((w_load && (w_sel == MSG_TIME)) || w_start_fall)
                r_pend_time <= 1'b0;
        end
    end

    assign w_rom_time = (r_state == ST_LOAD) ? w_time_live : r_time_snap;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^count_down;
    assign w_time_live  = 8'h00;
    assign w_pend_time  = 1'b0;
    assign w_rom_time   = w_time_live;
`endif

    // Fixed priority: OVER > START > SCORE > TIME
    always_comb begin
        w_sel = MSG_TIME;
        if (r_pend_over)       w_sel = MSG_OVER;
        else if (r_pend_start) w_sel = MSG_START;
        else if (r_pend_score) w_sel = MSG_SCORE;
    end

    // In LOAD the table sees the live selection and inputs so byte 0 can be
    // latched on the same edge as the snapshot; in WAIT_DONE it looks one
    // byte ahead so the next byte is ready when the UART frees up.
    assign w_rom_type  = (r_state == ST_LOAD) ? w_sel : r_msg_type;
    assign w_rom_score = (r_state == ST_LOAD) ? score : r_score_snap;
    assign w_rom_idx   = (r_state == ST_LOAD) ? '0 : (r_idx + 1'b1);

    msg_rom #(
        .SCORE_DIGITS (SCORE_DIGITS)
    ) u_msg_rom (
        .msg_type   (w_rom_type),
        .idx        (w_rom_idx),
        .score_snap (w_rom_score),
        .time_snap  (w_rom_time),
        .byte_out   (w_rom_byte),
        .last       (w_rom_last)
    );

    // Event detection and pending flags; a load clears its flag even if the
    // same event repeats that cycle, since the snapshot already holds it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_d    <= 1'b0;
            r_over_d     <= 1'b0;
            r_score_smp  <= '0;
            r_pend_start <= 1'b0;
            r_pend_over  <= 1'b0;
            r_pend_score <= 1'b0;
        end else begin
            r_start_d   <= start;
            r_over_d    <= over;
            r_score_smp <= score;
            if (start && !r_start_d)   r_pend_start <= 1'b1;
            if (over && !r_over_d)     r_pend_over  <= 1'b1;
            if (score != r_score_smp)  r_pend_score <= 1'b1;
            if (w_load) begin
                if (w_sel == MSG_OVER)  r_pend_over  <= 1'b0;
                if (w_sel == MSG_START) r_pend_start <= 1'b0;
                if (w_sel == MSG_SCORE) r_pend_score <= 1'b0;
            end
            if (w_start_fall) r_pend_score <= 1'b0;
        end
    end

    // Byte sequencer; transmit is set only on the edge entering STROBE and
    // only while the UART reports idle, so it is high for the STROBE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_msg_type   <= MSG_START;
            r_idx        <= '0;
            r_last       <= 1'b0;
            r_score_snap <= '0;
`ifdef REPORT_TIME_EN
            r_time_snap  <= 8'h00;
`endif
            transmit     <= 1'b0;
            tx_byte      <= 8'h00;
            busy         <= 1'b0;
        end else begin
            transmit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_pend) begin
                        r_state <= ST_LOAD;
                        busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!w_any_pend) begin
                        // Flags withdrawn by start falling before the load
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (!is_transmitting) begin
                        r_msg_type   <= w_sel;
                        r_score_snap <= score;
`ifdef REPORT_TIME_EN
                        r_time_snap  <= w_time_live;
`endif
                        r_idx        <= '0;
                        tx_byte      <= w_rom_byte;
                        r_last       <= w_rom_last;
                        transmit     <= 1'b1;
                        r_state      <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (is_transmitting) r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!is_transmitting) begin
                        if (r_last) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_idx    <= r_idx + 1'b1;
                            tx_byte  <= w_rom_byte;
                            r_last   <= w_rom_last;
                            transmit <= 1'b1;
                            r_state  <= ST_STROBE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
